// File: rtl/qkv_vector_sram.sv
// Per-operand vector buffer: fills DEPTH vectors from the memory controller, then streams them
// READ_PASSES times. Optional per-byte parity checking is enabled with `define QKV_SRAM_PARITY_EN.
module qkv_vector_sram #(
  parameter int DEPTH       = 64,
  parameter int VEC_BYTES   = 64,
  parameter int READ_PASSES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  logic [VEC_BYTES*8-1:0] wr_data,
  output logic                   wr_rdy,
  input  logic                   rd_rdy,
  output logic                   rd_vld,
  output logic [VEC_BYTES*8-1:0] rd_data,
  output logic                   rd_last,
  output logic                   full,
  output logic                   done,
  output logic                   rd_parity_err
);

  localparam int W      = VEC_BYTES * 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PASS_W = $clog2(READ_PASSES + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(READ_PASSES - 1);

  typedef enum logic [1:0] {ST_FILL, ST_PRIME, ST_STREAM, ST_DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where vld && rdy; the sender holds
  // its payload stable while vld is high and rdy is low.

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PASS_W-1:0] pass_cnt;
  logic [W-1:0]      mem [DEPTH];

  logic             wr_fire;
  logic             rd_fire;
  logic             last_pass_end;
  logic             load;
  logic [PTR_W-1:0] rd_addr;
  logic [W-1:0]     rd_word;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign wr_rdy        = (state == ST_FILL);
  assign wr_fire       = wr_vld && wr_rdy;
  assign rd_fire       = rd_vld && rd_rdy;
  assign last_pass_end = rd_fire && rd_last && (pass_cnt == PASS_LAST);
  assign load          = (state == ST_PRIME) ||
                         ((state == ST_STREAM) && rd_fire && !last_pass_end);

  // A new pass (and the prime) always restarts at entry 0.
  always_comb begin
    rd_addr = rd_ptr;
    if (state == ST_PRIME || rd_last) rd_addr = '0;
  end

  assign rd_word = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[wr_ptr] <= wr_data;
  end

`ifdef QKV_SRAM_PARITY_EN
  logic [VEC_BYTES-1:0] mem_par [DEPTH];
  logic                 parity_err_q;

  function automatic logic [VEC_BYTES-1:0] byte_parity(input logic [W-1:0] d);
    logic [VEC_BYTES-1:0] p;
    for (int b = 0; b < VEC_BYTES; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_par[wr_ptr] <= byte_parity(wr_data);
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else if (load) parity_err_q <= |(byte_parity(rd_word) ^ mem_par[rd_addr]);
  end

  assign rd_parity_err = parity_err_q;
`else
  assign rd_parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
      rd_data  <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      full     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (wr_fire) begin
            wr_ptr <= next_ptr(wr_ptr);
            if (wr_ptr == PTR_LAST) begin
              state <= ST_PRIME;
              full  <= 1'b1;
            end
          end
        end
        ST_PRIME: begin
          state  <= ST_STREAM;
          rd_vld <= 1'b1;
        end
        ST_STREAM: begin
          if (rd_fire && rd_last) pass_cnt <= pass_cnt + 1'b1;
          if (last_pass_end) begin
            state  <= ST_DONE;
            rd_vld <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
      // rd_last is cleared on the final consume because no new entry is held.
      if (load) begin
        rd_data <= rd_word;
        rd_last <= (rd_addr == PTR_LAST);
        rd_ptr  <= next_ptr(rd_addr);
      end else if (last_pass_end) begin
        rd_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qkv_vector_sram.sv
// Scoreboard bench for qkv_vector_sram (DEPTH=4, VEC_BYTES=8, READ_PASSES=2): fill, stream,
// stalls, mid-operation resets; the parity corruption case runs when QKV_SRAM_PARITY_EN is defined.
module tb_qkv_vector_sram;
  localparam int DEPTH       = 4;
  localparam int VEC_BYTES   = 8;
  localparam int READ_PASSES = 2;
  localparam int W           = VEC_BYTES * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_vld;
  logic [W-1:0] wr_data;
  logic         wr_rdy;
  logic         rd_rdy;
  logic         rd_vld;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic         full;
  logic         done;
  logic         rd_parity_err;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           idx_q[$];
  bit           corrupt = 1'b0;

  qkv_vector_sram #(
    .DEPTH(DEPTH), .VEC_BYTES(VEC_BYTES), .READ_PASSES(READ_PASSES)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last),
    .full(full), .done(done), .rd_parity_err(rd_parity_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec(input logic [7:0] b);
    return {VEC_BYTES{b}};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_vld  = 1'b0;
    rd_rdy  = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    idx_q.delete();
    check("rst_wr_rdy",  W'(wr_rdy), W'(1));
    check("rst_rd_vld",  W'(rd_vld), W'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_last", W'(rd_last), W'(0));
    check("rst_full",    W'(full), W'(0));
    check("rst_done",    W'(done), W'(0));
    check("rst_perr",    W'(rd_parity_err), W'(0));
  endtask

  // Writes n vectors base, base+1, ...; gappy applies wr_vld pattern 1,0,1,0,1,1.
  task automatic fill(input logic [7:0] base, input int n, input bit gappy);
    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int i = 0;
    int t = 0;
    while (i < n && t < 50) begin
      @(negedge clk);
      wr_vld  = gappy ? pat[t % 6] : 1'b1;
      wr_data = vec(base + 8'(i));
      if (wr_vld) begin
        check("fill_wr_rdy", W'(wr_rdy), W'(1));
        check("fill_full",   W'(full), W'(0));
        i++;
      end
      t++;
    end
    @(negedge clk);
    check("fill_count", W'(i), W'(n));
    if (n < DEPTH) begin
      wr_vld = 1'b0;
    end else begin
      // Keep offering junk during PRIME; it must be ignored.
      wr_data = '1;
      check("prime_wr_rdy", W'(wr_rdy), W'(0));
      check("prime_full",   W'(full), W'(1));
      check("prime_rd_vld", W'(rd_vld), W'(0));
      for (int p = 0; p < READ_PASSES; p++)
        for (int k = 0; k < DEPTH; k++) begin
          exp_q.push_back(vec(base + 8'(k)));
          idx_q.push_back(k);
        end
    end
  endtask

  // mode 0: rd_rdy always 1; 1: pattern 1,0,0,1 then 1; 2: random.
  task automatic stream(input int max_consume, input int mode);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cons = 0;
    int t = 0;
    int target;
    bit r;
    target = (max_consume < exp_q.size()) ? max_consume : exp_q.size();
    @(negedge clk);
    wr_vld = 1'b0;
    check("first_rd_vld", W'(rd_vld), W'(1));
    while (exp_q.size() > 0 && cons < max_consume && t < 200) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (t < 4) ? pat[t] : 1'b1;
      else                r = 1'($urandom_range(0, 1));
      rd_rdy = r;
      check("rd_vld",  W'(rd_vld), W'(1));
      check("rd_data", rd_data, exp_q[0]);
      check("rd_last", W'(rd_last), W'(idx_q[0] == DEPTH - 1));
      check("rd_perr", W'(rd_parity_err), W'(corrupt && idx_q[0] == 2));
      check("rd_ptr",  W'(dut.rd_ptr), W'((idx_q[0] + 1) % DEPTH));
      if (r) begin
        void'(exp_q.pop_front());
        void'(idx_q.pop_front());
        cons++;
      end
      t++;
      @(negedge clk);
    end
    check("stream_consumed", W'(cons), W'(target));
    if (exp_q.size() == 0) begin
      check("done_set",    W'(done), W'(1));
      check("done_rd_vld", W'(rd_vld), W'(0));
      check("done_wr_rdy", W'(wr_rdy), W'(0));
      @(negedge clk);
      check("done_held",   W'(done), W'(1));
      check("done_rd_vld_held", W'(rd_vld), W'(0));
    end
  endtask

  initial begin
    do_reset();

    fill(8'h10, DEPTH, 1'b0);
    stream(1000, 0);

    do_reset();
    fill(8'h10, DEPTH, 1'b1);
    stream(1000, 1);

    do_reset();
    fill(8'h30, 2, 1'b0);
    do_reset();
    fill(8'h50, DEPTH, 1'b0);
    stream(3, 0);
    do_reset();
    fill(8'h20, DEPTH, 1'b0);
    stream(1000, 2);

`ifdef QKV_SRAM_PARITY_EN
    do_reset();
    fill(8'h10, DEPTH, 1'b0);
    dut.mem[2][0] = ~dut.mem[2][0];
    for (int k = 0; k < exp_q.size(); k++)
      if (idx_q[k] == 2) exp_q[k][0] = ~exp_q[k][0];
    corrupt = 1'b1;
    stream(1000, 0);
    corrupt = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
